// File: rtl/ai_bus_ctrl_if.sv
// uart2bus internal bus between the text-command core (master) and ai_bus_ctrl (slave).
interface ai_bus_ctrl_if #(
  parameter int unsigned AW = 16
) ();

  logic [AW-1:0] int_address;
  logic [7:0]    int_wr_data;
  logic          int_write;
  logic          int_read;
  logic          int_req;
  logic          int_gnt;
  logic [7:0]    int_rd_data;

  modport master (
    output int_address, int_wr_data, int_write, int_read, int_req,
    input  int_gnt, int_rd_data
  );

  modport slave (
    input  int_address, int_wr_data, int_write, int_read, int_req,
    output int_gnt, int_rd_data
  );

endinterface

// File: rtl/ai_bus_ctrl.sv
// Bus-side controller for the 2048 AI search engine: board/depth registers, start/done/timeout FSM.
// Optional macro AI_RESULT_AUTOCLR_EN: a RESULT read in DONE clears done/tmo and returns to IDLE.
module ai_bus_ctrl #(
  parameter int unsigned AW             = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned DEF_DEPTH      = 3
) (
  input  logic                clock,
  input  logic                reset,
  ai_bus_ctrl_if.slave        bus,
  output logic [63:0]         eng_board,
  output logic [2:0]          eng_depth,
  output logic                eng_start,
  output logic                eng_abort,
  input  logic                eng_done,
  input  logic [1:0]          eng_dir
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e        state_q;
  logic [3:0]    cell_q [16];
  logic [2:0]    depth_q;
  logic [1:0]    dir_q;
  logic          done_q;
  logic          tmo_q;
  logic [CW-1:0] cnt_q;
  logic          gnt_q;
  logic [7:0]    rd_data_q;

  logic [AW-1:0] addr;
  logic          is_cell, is_ctrl, is_depth, is_result;
  logic          busy, wr_en, rd_en, start_req, clear_req;
  logic [7:0]    rd_mux;
  logic [63:0]   board_img;
  logic [2:0]    depth_wr;

  assign addr      = bus.int_address;
  assign is_cell   = (addr >> 4) == '0;
  assign is_ctrl   = addr == AW'(8'h10);
  assign is_depth  = addr == AW'(8'h11);
  assign is_result = addr == AW'(8'h13);

  assign busy      = (state_q == StLoad) || (state_q == StRun);
  assign wr_en     = bus.int_write && gnt_q;
  assign rd_en     = bus.int_read && gnt_q;
  assign start_req = wr_en && is_ctrl && bus.int_wr_data[0] &&
                     ((state_q == StIdle) || (state_q == StDone));
  assign clear_req = wr_en && is_ctrl && (bus.int_wr_data == 8'h00) && (state_q == StDone);
  assign depth_wr  = (bus.int_wr_data[2:0] == 3'd0) ? 3'd1 : bus.int_wr_data[2:0];

  always_comb begin
    board_img = '0;
    for (int i = 0; i < 16; i++) begin
      board_img[4*i +: 4] = cell_q[i];
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    if (is_cell) begin
      rd_mux = {4'h0, cell_q[addr[3:0]]};
    end else if (is_ctrl) begin
      rd_mux = {6'b0, busy, done_q};
    end else if (is_depth) begin
      rd_mux = {5'b0, depth_q};
    end else if (is_result) begin
      rd_mux = {busy, done_q, tmo_q, 3'b0, dir_q};
    end
  end

  assign bus.int_gnt     = gnt_q;
  assign bus.int_rd_data = rd_data_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      for (int i = 0; i < 16; i++) begin
        cell_q[i] <= '0;
      end
      depth_q   <= 3'(DEF_DEPTH);
      dir_q     <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= 1'b0;
      rd_data_q <= '0;
      eng_board <= '0;
      eng_depth <= 3'(DEF_DEPTH);
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;

      // Once granted the bus stays granted through LOAD; a new grant is never issued in LOAD.
      if (!bus.int_req) begin
        gnt_q <= 1'b0;
      end else if (state_q != StLoad) begin
        gnt_q <= 1'b1;
      end

      if (rd_en) begin
        rd_data_q <= rd_mux;
      end
      if (wr_en && is_cell && !busy) begin
        cell_q[addr[3:0]] <= bus.int_wr_data[3:0];
      end
      if (wr_en && is_depth && !busy) begin
        depth_q <= depth_wr;
      end

      if (start_req) begin
        // Snapshot on the launch edge so eng_board/eng_depth are stable while eng_start is high.
        state_q   <= StLoad;
        eng_start <= 1'b1;
        eng_board <= board_img;
        eng_depth <= depth_q;
        cnt_q     <= '0;
        done_q    <= 1'b0;
        tmo_q     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StIdle;
          StLoad: begin
            cnt_q   <= cnt_q + CW'(1);
            state_q <= StRun;
          end
          StRun: begin
            // cnt_q counts cycles since eng_start; eng_done wins a tie with expiry.
            if (eng_done) begin
              dir_q   <= eng_dir;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (cnt_q + CW'(1) == CW'(TIMEOUT_CYCLES)) begin
              eng_abort <= 1'b1;
              tmo_q     <= 1'b1;
              done_q    <= 1'b1;
              dir_q     <= '0;
              state_q   <= StDone;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StDone: begin
            if (clear_req) begin
              done_q  <= 1'b0;
              tmo_q   <= 1'b0;
              state_q <= StIdle;
            end
`ifdef AI_RESULT_AUTOCLR_EN
            else if (rd_en && is_result) begin
              done_q  <= 1'b0;
              tmo_q   <= 1'b0;
              state_q <= StIdle;
            end
`endif
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ai_bus_ctrl.sv
// Directed self-checking bench for ai_bus_ctrl (TIMEOUT_CYCLES shortened to 20).
module tb_ai_bus_ctrl;

  localparam int unsigned AW  = 16;
  localparam int unsigned TMO = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] eng_board;
  logic [2:0]  eng_depth;
  logic        eng_start;
  logic        eng_abort;
  logic        eng_done;
  logic [1:0]  eng_dir;

  ai_bus_ctrl_if #(.AW(AW)) bus ();

  ai_bus_ctrl #(
    .AW             (AW),
    .TIMEOUT_CYCLES (TMO),
    .DEF_DEPTH      (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .eng_board (eng_board),
    .eng_depth (eng_depth),
    .eng_start (eng_start),
    .eng_abort (eng_abort),
    .eng_done  (eng_done),
    .eng_dir   (eng_dir)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bus_wr(input logic [AW-1:0] a, input logic [7:0] d);
    bus.int_address = a;
    bus.int_wr_data = d;
    bus.int_write   = 1'b1;
    step(1);
    bus.int_write   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    bus.int_address = a;
    bus.int_read    = 1'b1;
    step(1);
    bus.int_read    = 1'b0;
    check_eq(tag, {56'h0, bus.int_rd_data}, {56'h0, exp});
  endtask

  task automatic pulse_done(input logic [1:0] d);
    eng_done = 1'b1;
    eng_dir  = d;
    step(1);
    eng_done = 1'b0;
    eng_dir  = 2'd0;
  endtask

  initial begin
    int seen;
    reset           = 1'b1;
    eng_done        = 1'b0;
    eng_dir         = 2'd0;
    bus.int_address = '0;
    bus.int_wr_data = '0;
    bus.int_write   = 1'b0;
    bus.int_read    = 1'b0;
    bus.int_req     = 1'b0;
    step(2);
    reset = 1'b0;
    step(1);

    check_eq("rst_gnt", {63'h0, bus.int_gnt}, 64'h0);
    check_eq("rst_rd_data", {56'h0, bus.int_rd_data}, 64'h0);
    check_eq("rst_start", {63'h0, eng_start}, 64'h0);
    check_eq("rst_abort", {63'h0, eng_abort}, 64'h0);
    check_eq("rst_board", eng_board, 64'h0);
    check_eq("rst_depth", {61'h0, eng_depth}, 64'h3);

    // Write without grant must be dropped.
    bus_wr(16'h0003, 8'h09);
    step(1);
    check_eq("gnt_idle", {63'h0, bus.int_gnt}, 64'h0);
    bus.int_req = 1'b1;
    step(1);
    check_eq("gnt_rise", {63'h0, bus.int_gnt}, 64'h1);

    rd_check("rd_ctrl_rst", 16'h0010, 8'h00);
    rd_check("rd_depth_rst", 16'h0011, 8'h03);
    rd_check("rd_result_rst", 16'h0013, 8'h00);
    rd_check("ungranted_wr", 16'h0003, 8'h00);

    bus_wr(16'h0000, 8'h01);
    bus_wr(16'h000F, 8'h1B);
    rd_check("cell0", 16'h0000, 8'h01);
    rd_check("cellF", 16'h000F, 8'h0B);
    bus_wr(16'h0012, 8'hFF);
    rd_check("unused_12", 16'h0012, 8'h00);
    rd_check("alias_0100", 16'h0100, 8'h00);

    // Start search; snapshot must be visible with eng_start.
    bus_wr(16'h0010, 8'h01);
    check_eq("start_pulse", {63'h0, eng_start}, 64'h1);
    check_eq("start_board", eng_board, 64'hB000_0000_0000_0001);
    check_eq("start_depth", {61'h0, eng_depth}, 64'h3);
    bus_wr(16'h0005, 8'h07);
    check_eq("start_1cyc", {63'h0, eng_start}, 64'h0);
    bus_wr(16'h0011, 8'h00);
    rd_check("busy_cell_drop", 16'h0005, 8'h00);
    rd_check("busy_depth_drop", 16'h0011, 8'h03);
    rd_check("ctrl_busy", 16'h0010, 8'h02);
    check_eq("board_held", eng_board, 64'hB000_0000_0000_0001);
    pulse_done(2'd2);
    rd_check("ctrl_done", 16'h0010, 8'h01);
    rd_check("result_dir2", 16'h0013, 8'h42);

    // Depth write 0 stored as 1, then a real depth, then timeout run.
    bus_wr(16'h0011, 8'h00);
    rd_check("depth_zero", 16'h0011, 8'h01);
    bus_wr(16'h0011, 8'h05);
    rd_check("depth_five", 16'h0011, 8'h05);
    bus_wr(16'h0010, 8'h01);
    check_eq("tmo_start", {63'h0, eng_start}, 64'h1);
    check_eq("tmo_depth", {61'h0, eng_depth}, 64'h5);
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (eng_abort) begin
        seen = i;
        break;
      end
    end
    check_eq("abort_delay", 64'(seen), 64'(TMO));
    step(1);
    check_eq("abort_1cyc", {63'h0, eng_abort}, 64'h0);
    rd_check("result_tmo", 16'h0013, 8'h60);
    bus_wr(16'h0010, 8'h00);
    rd_check("result_clr", 16'h0013, 8'h00);
    rd_check("ctrl_clr", 16'h0010, 8'h00);

    // eng_done on the expiry cycle wins.
    bus_wr(16'h0010, 8'h01);
    step(TMO - 1);
    eng_done = 1'b1;
    eng_dir  = 2'd3;
    step(1);
    eng_done = 1'b0;
    eng_dir  = 2'd0;
    check_eq("tie_no_abort", {63'h0, eng_abort}, 64'h0);
    step(1);
    check_eq("tie_no_abort2", {63'h0, eng_abort}, 64'h0);
    rd_check("tie_result", 16'h0013, 8'h43);
    bus_wr(16'h0010, 8'h00);

    // RESULT read side effects.
    bus_wr(16'h0010, 8'h01);
    step(2);
    pulse_done(2'd1);
    rd_check("result_rd1", 16'h0013, 8'h41);
`ifdef AI_RESULT_AUTOCLR_EN
    rd_check("autoclr_rd2", 16'h0013, 8'h01);
    rd_check("autoclr_ctrl", 16'h0010, 8'h00);
`else
    rd_check("persist_rd2", 16'h0013, 8'h41);
    rd_check("persist_ctrl", 16'h0010, 8'h01);
`endif

    // Reset mid-RUN.
    bus_wr(16'h0010, 8'h01);
    step(3);
    reset = 1'b1;
    step(1);
    check_eq("mid_rst_gnt", {63'h0, bus.int_gnt}, 64'h0);
    check_eq("mid_rst_rd", {56'h0, bus.int_rd_data}, 64'h0);
    check_eq("mid_rst_start", {63'h0, eng_start}, 64'h0);
    check_eq("mid_rst_abort", {63'h0, eng_abort}, 64'h0);
    check_eq("mid_rst_board", eng_board, 64'h0);
    check_eq("mid_rst_depth", {61'h0, eng_depth}, 64'h3);
    reset = 1'b0;
    pulse_done(2'd3);
    step(1);
    check_eq("regrant", {63'h0, bus.int_gnt}, 64'h1);
    rd_check("post_rst_result", 16'h0013, 8'h00);
    rd_check("post_rst_ctrl", 16'h0010, 8'h00);
    rd_check("post_rst_cell0", 16'h0000, 8'h00);
    rd_check("post_rst_depth", 16'h0011, 8'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
